// File: rtl/tdr_seq_pkg.sv
// ============================================================================
// Module : tdr_seq_pkg
// Desc   : Shared state encoding and default sizing for the TDR write sequencer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tdr_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CLR  = 3'd1,
        S_WR0  = 3'd2,
        S_GAP0 = 3'd3,
        S_WR1  = 3'd4,
        S_GAP1 = 3'd5,
        S_READ = 3'd6,
        S_DONE = 3'd7
    } state_t;

    localparam int c_DEF_CNT_W      = 8;
    localparam int c_DEF_GAP_CYC    = 2;
    localparam int c_DEF_RD_TIMEOUT = 255;

endpackage

`default_nettype wire

// File: rtl/tdr_sync2.sv
// ============================================================================
// Module : tdr_sync2
// Desc   : Generic two-flop synchronizer for a single asynchronous bit.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tdr_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/tdr_write_sequencer.sv
// ============================================================================
// Module : tdr_write_sequencer
// Desc   : Drives WE0/WE1/RE/rstb of the time-domain register and measures the
//          width of its out pulse. Define TDR_SEQ_SYNC_EN to synchronize the
//          register's out/carry pins through two-flop synchronizers.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tdr_write_sequencer
    import tdr_seq_pkg::*;
#(
    parameter int CNT_W      = c_DEF_CNT_W,
    parameter int GAP_CYC    = c_DEF_GAP_CYC,
    parameter int RD_TIMEOUT = c_DEF_RD_TIMEOUT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] t0_i,
    input  logic [CNT_W-1:0] t1_i,
    output logic             ready_o,
    output logic             done_o,
    output logic [CNT_W-1:0] result_o,
    output logic             carry_flag_o,
    output logic             timeout_o,
    output logic             WE0_o,
    output logic             WE1_o,
    output logic             RE_o,
    output logic             rstb_o,
    input  logic             tdr_out_i,
    input  logic             tdr_carry_i
);

    localparam int c_GAP_W = $clog2(GAP_CYC + 1);
    localparam int c_PH_W  = (CNT_W > c_GAP_W) ? CNT_W : c_GAP_W;
    localparam int c_RD_W  = $clog2(RD_TIMEOUT + 1);

    localparam logic [c_PH_W-1:0] c_PH_ONE   = c_PH_W'(1);
    localparam logic [c_PH_W-1:0] c_GAP_LAST = c_PH_W'(GAP_CYC - 1);
    localparam logic [c_RD_W-1:0] c_RD_ONE   = c_RD_W'(1);
    localparam logic [c_RD_W-1:0] c_RD_LAST  = c_RD_W'(RD_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  c_RES_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  c_RES_MAX  = '1;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_t0;
    logic [CNT_W-1:0]    r_t1;
    logic [c_PH_W-1:0]   r_ph;
    logic [c_PH_W-1:0]   w_ph_nxt;
    logic [c_RD_W-1:0]   r_rd;
    logic [c_RD_W-1:0]   w_rd_nxt;
    logic                w_tmo_exit;
    logic                r_prev;
    logic [CNT_W-1:0]    r_result;
    logic                r_carry;
    logic                r_timeout;
    logic                r_ready;
    logic                r_done;
    logic                r_we0;
    logic                r_we1;
    logic                r_re;
    logic                r_rstb;
    logic                w_out;
    logic                w_carry;

`ifdef TDR_SEQ_SYNC_EN
    tdr_sync2 u_sync_out (
        .clk (clk_i),
        .rst (rst_i),
        .i_d (tdr_out_i),
        .o_q (w_out)
    );

    tdr_sync2 u_sync_carry (
        .clk (clk_i),
        .rst (rst_i),
        .i_d (tdr_carry_i),
        .o_q (w_carry)
    );
`else
    assign w_out   = tdr_out_i;
    assign w_carry = tdr_carry_i;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // r_ph holds the cycles remaining in the current timed phase, minus one.
    always_comb begin
        w_state_nxt = r_state;
        w_ph_nxt    = r_ph;
        w_rd_nxt    = r_rd;
        w_tmo_exit  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_state_nxt = S_CLR;
                end
            end
            S_CLR: begin
                if (r_t0 != '0) begin
                    w_state_nxt = S_WR0;
                    w_ph_nxt    = c_PH_W'(r_t0) - c_PH_ONE;
                end else begin
                    w_state_nxt = S_GAP0;
                    w_ph_nxt    = c_GAP_LAST;
                end
            end
            S_WR0: begin
                if (r_ph == '0) begin
                    w_state_nxt = S_GAP0;
                    w_ph_nxt    = c_GAP_LAST;
                end else begin
                    w_ph_nxt = r_ph - c_PH_ONE;
                end
            end
            S_GAP0: begin
                if (r_ph != '0) begin
                    w_ph_nxt = r_ph - c_PH_ONE;
                end else if (r_t1 != '0) begin
                    w_state_nxt = S_WR1;
                    w_ph_nxt    = c_PH_W'(r_t1) - c_PH_ONE;
                end else begin
                    w_state_nxt = S_GAP1;
                    w_ph_nxt    = c_GAP_LAST;
                end
            end
            S_WR1: begin
                if (r_ph == '0) begin
                    w_state_nxt = S_GAP1;
                    w_ph_nxt    = c_GAP_LAST;
                end else begin
                    w_ph_nxt = r_ph - c_PH_ONE;
                end
            end
            S_GAP1: begin
                if (r_ph == '0) begin
                    w_state_nxt = S_READ;
                    w_rd_nxt    = '0;
                end else begin
                    w_ph_nxt = r_ph - c_PH_ONE;
                end
            end
            S_READ: begin
                if (r_prev && !w_out) begin
                    w_state_nxt = S_DONE;
                end else if (r_rd == c_RD_LAST) begin
                    w_state_nxt = S_DONE;
                    w_tmo_exit  = 1'b1;
                end else begin
                    w_rd_nxt = r_rd + c_RD_ONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Pin drives are decoded from the next state so they change with the state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_t0      <= '0;
            r_t1      <= '0;
            r_ph      <= '0;
            r_rd      <= '0;
            r_prev    <= 1'b0;
            r_result  <= '0;
            r_carry   <= 1'b0;
            r_timeout <= 1'b0;
            r_ready   <= 1'b1;
            r_done    <= 1'b0;
            r_we0     <= 1'b0;
            r_we1     <= 1'b0;
            r_re      <= 1'b0;
            r_rstb    <= 1'b0;
        end else begin
            r_ph    <= w_ph_nxt;
            r_rd    <= w_rd_nxt;
            r_ready <= (w_state_nxt == S_IDLE);
            r_rstb  <= (w_state_nxt != S_CLR);
            r_we0   <= (w_state_nxt == S_WR0);
            r_we1   <= (w_state_nxt == S_WR1);
            r_re    <= (w_state_nxt == S_READ);
            r_done  <= (w_state_nxt == S_DONE);

            if (r_state == S_IDLE && start_i) begin
                r_t0      <= t0_i;
                r_t1      <= t1_i;
                r_result  <= '0;
                r_carry   <= 1'b0;
                r_timeout <= 1'b0;
            end

            if (r_state == S_READ) begin
                r_prev <= w_out;
                if (w_out && r_result != c_RES_MAX) begin
                    r_result <= r_result + c_RES_ONE;
                end
                r_carry <= r_carry | w_carry;
                if (w_tmo_exit) begin
                    r_timeout <= 1'b1;
                end
            end else begin
                r_prev <= 1'b0;
            end
        end
    end

    assign ready_o      = r_ready;
    assign done_o       = r_done;
    assign result_o     = r_result;
    assign carry_flag_o = r_carry;
    assign timeout_o    = r_timeout;
    assign WE0_o        = r_we0;
    assign WE1_o        = r_we1;
    assign RE_o         = r_re;
    assign rstb_o       = r_rstb;

endmodule

`default_nettype wire

// File: tb/tb_tdr_write_sequencer.sv
// ============================================================================
// Module : tb_tdr_write_sequencer
// Desc   : Directed self-checking bench for tdr_write_sequencer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tdr_write_sequencer;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_i = 1'b1;
    logic             start_i = 1'b0;
    logic [CNT_W-1:0] t0_i = '0;
    logic [CNT_W-1:0] t1_i = '0;
    logic             tdr_out_i = 1'b0;
    logic             tdr_carry_i = 1'b0;
    logic             ready_o, done_o, carry_flag_o, timeout_o;
    logic             WE0_o, WE1_o, RE_o, rstb_o;
    logic [CNT_W-1:0] result_o;

    logic             start4 = 1'b0;
    logic             out4 = 1'b0;
    logic             carry4 = 1'b0;
    logic             ready4, done4, carry_flag4, timeout4;
    logic             we0_4, we1_4, re4, rstb4;
    logic [CNT_W-1:0] result4;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    tdr_write_sequencer #(.CNT_W(CNT_W), .GAP_CYC(2), .RD_TIMEOUT(255)) u_dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .t0_i         (t0_i),
        .t1_i         (t1_i),
        .ready_o      (ready_o),
        .done_o       (done_o),
        .result_o     (result_o),
        .carry_flag_o (carry_flag_o),
        .timeout_o    (timeout_o),
        .WE0_o        (WE0_o),
        .WE1_o        (WE1_o),
        .RE_o         (RE_o),
        .rstb_o       (rstb_o),
        .tdr_out_i    (tdr_out_i),
        .tdr_carry_i  (tdr_carry_i)
    );

    tdr_write_sequencer #(.CNT_W(CNT_W), .GAP_CYC(2), .RD_TIMEOUT(400)) u_dut400 (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .start_i      (start4),
        .t0_i         (t0_i),
        .t1_i         (t1_i),
        .ready_o      (ready4),
        .done_o       (done4),
        .result_o     (result4),
        .carry_flag_o (carry_flag4),
        .timeout_o    (timeout4),
        .WE0_o        (we0_4),
        .WE1_o        (we1_4),
        .RE_o         (re4),
        .rstb_o       (rstb4),
        .tdr_out_i    (out4),
        .tdr_carry_i  (carry4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input int a0, input int a1);
        t0_i    = CNT_W'(a0);
        t1_i    = CNT_W'(a1);
        start_i = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    // {ready, rstb, WE0, WE1, RE} k cycles after the accepting edge, GAP_CYC=2
    function automatic logic [4:0] exp_vec(input int k, input int a0, input int a1);
        logic rstb, we0, we1, re;
        rstb = (k != 0);
        we0  = (k >= 1) && (k <= a0);
        we1  = (k >= a0 + 3) && (k < a0 + 3 + a1);
        re   = (k >= a0 + a1 + 5);
        return {1'b0, rstb, we0, we1, re};
    endfunction

    // Checks pin timing from the accepting edge up to the first READ cycle.
    task automatic run_phases(input int a0, input int a1);
        int last;
        last = a0 + a1 + 5;
        for (int k = 0; k <= last; k++) begin
            check($sformatf("phase t0=%0d t1=%0d k=%0d", a0, a1, k),
                  {27'd0, ready_o, rstb_o, WE0_o, WE1_o, RE_o}, {27'd0, exp_vec(k, a0, a1)});
            if (k < last) step();
        end
    endtask

    task automatic wait_done(input int bound);
        int i;
        i = 0;
        while (!done_o && i < bound) begin
            step();
            i++;
        end
        check("done_seen", {31'd0, done_o}, 32'd1);
    endtask

    initial begin
        int re_cyc;
        int i;

        // reset state
        repeat (3) step();
        check("reset_flags", {24'd0, ready_o, rstb_o, WE0_o, WE1_o, RE_o, done_o, timeout_o, carry_flag_o},
              32'h80);
        check("reset_result", {24'd0, result_o}, 32'd0);
        rst_i = 1'b0;
        step();
        check("idle_rstb", {30'd0, ready_o, rstb_o}, 32'd3);

        // t0=3, t1=5, out high for 8 READ cycles
        start_op(3, 5);
        run_phases(3, 5);
        tdr_out_i = 1'b1;
        repeat (8) step();
        tdr_out_i = 1'b0;
        wait_done(20);
        check("t1_result", {24'd0, result_o}, 32'd8);
        check("t1_flags", {30'd0, carry_flag_o, timeout_o}, 32'd0);
        step();
        check("t1_done_pulse", {31'd0, done_o}, 32'd0);
        check("t1_ready", {31'd0, ready_o}, 32'd1);

        // WE0 phase skipped
        start_op(0, 4);
        run_phases(0, 4);
        tdr_out_i = 1'b1;
        repeat (3) step();
        tdr_out_i = 1'b0;
        wait_done(20);
        check("t2_result", {24'd0, result_o}, 32'd3);
        step();

        // both phases skipped, out stuck high -> timeout
        start_op(0, 0);
        run_phases(0, 0);
        tdr_out_i = 1'b1;
        re_cyc = 0;
        while (RE_o && re_cyc < 300) begin
            re_cyc++;
            step();
        end
        check("t3_read_len", re_cyc, 32'd255);
        check("t3_done", {31'd0, done_o}, 32'd1);
        check("t3_result", {24'd0, result_o}, 32'd255);
        check("t3_timeout", {31'd0, timeout_o}, 32'd1);
        check("t3_carry", {31'd0, carry_flag_o}, 32'd0);
        tdr_out_i = 1'b0;
        step();
        check("t3_ready", {31'd0, ready_o}, 32'd1);

        // RD_TIMEOUT=400: carry pulse, out high 300 cycles saturates result
        t0_i   = 8'd1;
        t1_i   = 8'd1;
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        i = 0;
        while (!re4 && i < 20) begin
            step();
            i++;
        end
        check("t4_re_seen", {31'd0, re4}, 32'd1);
        out4 = 1'b1;
        repeat (10) step();
        carry4 = 1'b1;
        step();
        carry4 = 1'b0;
        repeat (289) step();
        out4 = 1'b0;
        i = 0;
        while (!done4 && i < 20) begin
            step();
            i++;
        end
        check("t4_done", {31'd0, done4}, 32'd1);
        check("t4_result", {24'd0, result4}, 32'd255);
        check("t4_flags", {30'd0, carry_flag4, timeout4}, 32'd2);
        step();

        // busy start ignored, then reset during WR1
        start_op(2, 6);
        step();
        t0_i    = 8'd7;
        t1_i    = 8'd9;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        check("t5_we0_k2", {31'd0, WE0_o}, 32'd1);
        step();
        step();
        check("t5_we1_k4", {31'd0, WE1_o}, 32'd0);
        step();
        check("t5_we1_k5", {30'd0, WE1_o, ready_o}, 32'd2);
        step();
        step();
        rst_i = 1'b1;
        #1;
        check("t5_async_rst", {24'd0, ready_o, rstb_o, WE0_o, WE1_o, RE_o, done_o, timeout_o, carry_flag_o},
              32'h80);
        check("t5_rst_result", {24'd0, result_o}, 32'd0);
        step();
        rst_i = 1'b0;
        step();
        start_op(1, 1);
        run_phases(1, 1);
        tdr_out_i = 1'b1;
        repeat (2) step();
        tdr_out_i = 1'b0;
        wait_done(20);
        check("t5_result", {24'd0, result_o}, 32'd2);
        step();
        check("t5_ready", {31'd0, ready_o}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
